// File: rtl/edge_event_arbiter_pkg.sv
// Shared types and helpers for the edge event arbiter.
package edge_event_arbiter_pkg;

    // Arbiter FSM: IDLE picks the next pending channel, PRESENT holds it until accepted.
    typedef enum logic {
        StIdle    = 1'b0,
        StPresent = 1'b1
    } arb_state_e;

    // Ceiling log2 for sizing the channel index; callers guarantee value >= 2.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/edge_event_arbiter_rr_picker.sv
// Combinational rotate-priority picker: first set request after 'last', wrapping.
module edge_event_arbiter_rr_picker #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] pick,
    output logic             found
);

    int unsigned cand;

    // Walk the channels starting one past the last grant; the first request wins.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned d = 1; d <= WIDTH; d++) begin
            cand = (32'(last) + d) % WIDTH;
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Edge-capturing event arbiter: latches per-channel edges as pending events and
// serialises them round-robin over valid/ready. Optional per-event timestamps are
// enabled by defining EDGE_EVENT_TIMESTAMP_EN.
module edge_event_arbiter
    import edge_event_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter logic        RISE_DETECTOR = 1'b1,
    parameter int unsigned TS_W          = 16,
    localparam int unsigned IDX_W        = clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] iv_input,
    input  logic [WIDTH-1:0] iv_enable,
    output logic [IDX_W-1:0] ov_index,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] ov_pending,
`ifdef EDGE_EVENT_TIMESTAMP_EN
    output logic [TS_W-1:0]  ov_timestamp,
`endif
    output logic [WIDTH-1:0] ov_overflow,
    input  logic             i_clear_overflow
);

    arb_state_e       state_q, state_d;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] overflow_q, overflow_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] edge_vec;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] accept_vec;
    logic [WIDTH-1:0] held;
    logic             xfer;
    logic [IDX_W-1:0] pick;
    logic             found;

    assign edge_vec = RISE_DETECTOR ? (~prev_q & iv_input) : (prev_q & ~iv_input);
    assign capture  = edge_vec & iv_enable;
    assign xfer     = valid_q & i_ready;

    // One-hot of the channel being accepted this cycle (zero when no transfer).
    always_comb begin
        accept_vec = '0;
        if (xfer) begin
            accept_vec[index_q] = 1'b1;
        end
    end

    // A pending bit that survives this cycle; a capture on top of it is an overflow,
    // while a capture on the channel being accepted is simply a fresh event.
    assign held       = pending_q & ~accept_vec;
    assign pending_d  = held | capture;
    assign overflow_d = (i_clear_overflow ? '0 : overflow_q) | (capture & held);

    edge_event_arbiter_rr_picker #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .req   (pending_q),
        .last  (last_q),
        .pick  (pick),
        .found (found)
    );

    // FSM next state: present a picked channel, then hold it until the consumer accepts.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        index_d = index_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    index_d = pick;
                    valid_d = 1'b1;
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    last_d  = index_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; prev resets to the active level so a held input gives no event.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            prev_q     <= {WIDTH{RISE_DETECTOR}};
            pending_q  <= '0;
            overflow_q <= '0;
            index_q    <= '0;
            last_q     <= IDX_W'(WIDTH - 1);
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= iv_input;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            index_q    <= index_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
        end
    end

    assign ov_index    = index_q;
    assign o_valid     = valid_q;
    assign ov_pending  = pending_q;
    assign ov_overflow = overflow_q;

`ifdef EDGE_EVENT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_count_q;
    logic [TS_W-1:0] stamp_q [WIDTH];
    logic [TS_W-1:0] timestamp_q;

    // Free-running counter, stamps taken when a pending bit is (re)set, and the
    // presented stamp loaded alongside the index.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ts_count_q  <= '0;
            timestamp_q <= '0;
            for (int k = 0; k < int'(WIDTH); k++) begin
                stamp_q[k] <= '0;
            end
        end else begin
            ts_count_q <= ts_count_q + TS_W'(1);
            for (int k = 0; k < int'(WIDTH); k++) begin
                if (capture[k] && !held[k]) begin
                    stamp_q[k] <= ts_count_q;
                end
            end
            if (state_q == StIdle && found) begin
                timestamp_q <= stamp_q[pick];
            end
        end
    end

    assign ov_timestamp = timestamp_q;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a reference model.
module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_v = 8'hFF;
    logic [7:0] en_v = 8'hFF;
    logic       rdy = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] idx;
    logic       valid;
    logic [7:0] pend;
    logic [7:0] ovf;

    logic       rst_f = 1'b1;
    logic [7:0] in_f = 8'hFF;
    logic       rdy_f = 1'b0;
    logic [2:0] idx_f;
    logic       valid_f;
    logic [7:0] pend_f;
    logic [7:0] ovf_f;

`ifdef EDGE_EVENT_TIMESTAMP_EN
    logic [15:0] ts_main;
    logic [15:0] ts_f;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    edge_event_arbiter #(
        .WIDTH         (8),
        .RISE_DETECTOR (1'b1),
        .TS_W          (16)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .iv_input         (in_v),
        .iv_enable        (en_v),
        .ov_index         (idx),
        .o_valid          (valid),
        .i_ready          (rdy),
        .ov_pending       (pend),
`ifdef EDGE_EVENT_TIMESTAMP_EN
        .ov_timestamp     (ts_main),
`endif
        .ov_overflow      (ovf),
        .i_clear_overflow (clr)
    );

    edge_event_arbiter #(
        .WIDTH         (8),
        .RISE_DETECTOR (1'b0),
        .TS_W          (16)
    ) dut_f (
        .i_clk            (clk),
        .i_rst            (rst_f),
        .iv_input         (in_f),
        .iv_enable        (8'hFF),
        .ov_index         (idx_f),
        .o_valid          (valid_f),
        .i_ready          (rdy_f),
        .ov_pending       (pend_f),
`ifdef EDGE_EVENT_TIMESTAMP_EN
        .ov_timestamp     (ts_f),
`endif
        .ov_overflow      (ovf_f),
        .i_clear_overflow (1'b0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model of the rise-mode instance: a set of pending channels, the event
    // on offer, and the last channel served.
    logic [7:0] m_prev;
    logic [7:0] m_pend;
    logic [7:0] m_ovf;
    bit         m_valid;
    int         m_idx;
    int         m_last;

    always @(posedge clk or posedge rst) begin : model
        logic [7:0] np;
        logic [7:0] no;
        bit         nv;
        bit         got;
        int         ni;
        int         nl;
        int         c;
        if (rst) begin
            m_prev  <= 8'hFF;
            m_pend  <= 8'h00;
            m_ovf   <= 8'h00;
            m_valid <= 1'b0;
            m_idx   <= 0;
            m_last  <= 7;
        end else begin
            np  = m_pend;
            no  = clr ? 8'h00 : m_ovf;
            nv  = m_valid;
            ni  = m_idx;
            nl  = m_last;
            got = 1'b0;
            if (m_valid && rdy) begin
                np[m_idx] = 1'b0;
                nv        = 1'b0;
                nl        = m_idx;
            end else if (!m_valid) begin
                for (int d = 1; d <= 8; d++) begin
                    c = (m_last + d) % 8;
                    if (!got && m_pend[c]) begin
                        got = 1'b1;
                        ni  = c;
                        nv  = 1'b1;
                    end
                end
            end
            for (int k = 0; k < 8; k++) begin
                if (!m_prev[k] && in_v[k] && en_v[k]) begin
                    if (np[k]) no[k] = 1'b1;
                    np[k] = 1'b1;
                end
            end
            m_prev  <= in_v;
            m_pend  <= np;
            m_ovf   <= no;
            m_valid <= nv;
            m_idx   <= ni;
            m_last  <= nl;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model_valid", {31'd0, valid}, {31'd0, m_valid});
            if (m_valid) check("model_index", {29'd0, idx}, m_idx);
            check("model_pending", {24'd0, pend}, {24'd0, m_pend});
            check("model_overflow", {24'd0, ovf}, {24'd0, m_ovf});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance at least one cycle, then wait (bounded) for an event and check its index.
    task automatic expect_event(input int exp_idx, input string name);
        int waited;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!valid && waited < 12);
        check({name, "_valid"}, {31'd0, valid}, 32'd1);
        check(name, {29'd0, idx}, exp_idx);
    endtask

    initial begin
        logic [7:0] flip;

        // Reset with inputs held high: no events afterwards.
        repeat (5) tick();
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_pending", {24'd0, pend}, 32'd0);
        rst = 1'b0;
        repeat (3) tick();
        check("held_valid", {31'd0, valid}, 32'd0);
        check("held_pending", {24'd0, pend}, 32'd0);
        in_v = 8'h00;
        tick();
        check("fall_ignored", {24'd0, pend}, 32'd0);

        // Single rising edge on ch3.
        in_v = 8'h08;
        rdy  = 1'b1;
        tick();
        check("ch3_pending", {24'd0, pend}, 32'h08);
        check("ch3_valid_n", {31'd0, valid}, 32'd0);
        tick();
        check("ch3_valid", {31'd0, valid}, 32'd1);
        check("ch3_index", {29'd0, idx}, 32'd3);
        tick();
        check("ch3_done_valid", {31'd0, valid}, 32'd0);
        check("ch3_done_pending", {24'd0, pend}, 32'd0);
        in_v = 8'h00;
        tick();

        // Fresh reset so channel 0 has first priority again.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        in_v = 8'h62;
        tick();
        expect_event(1, "rr_a1");
        expect_event(5, "rr_a5");
        expect_event(6, "rr_a6");
        in_v = 8'h00;
        tick();
        in_v = 8'h42;
        tick();
        expect_event(1, "rr_b1");
        expect_event(6, "rr_b6");
        tick();

        // Overflow on ch2 while the consumer stalls.
        rdy  = 1'b0;
        in_v = 8'h00;
        tick();
        in_v = 8'h04;
        tick();
        in_v = 8'h00;
        tick();
        check("ovf_first_index", {29'd0, idx}, 32'd2);
        in_v = 8'h04;
        tick();
        check("ovf_flag", {24'd0, ovf}, 32'h04);
        check("ovf_pending", {24'd0, pend}, 32'h04);
        rdy = 1'b1;
        tick();
        check("ovf_xfer_valid", {31'd0, valid}, 32'd0);
        check("ovf_xfer_pending", {24'd0, pend}, 32'd0);
        repeat (2) tick();
        check("ovf_single_event", {31'd0, valid}, 32'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("ovf_cleared", {24'd0, ovf}, 32'd0);

        // New edge on ch4 in the very cycle ch4 is accepted.
        rdy  = 1'b0;
        in_v = 8'h00;
        tick();
        in_v = 8'h10;
        tick();
        in_v = 8'h00;
        tick();
        check("coll_valid", {31'd0, valid}, 32'd1);
        check("coll_index", {29'd0, idx}, 32'd4);
        rdy  = 1'b1;
        in_v = 8'h10;
        tick();
        check("coll_pending", {24'd0, pend}, 32'h10);
        check("coll_no_ovf", {24'd0, ovf}, 32'd0);
        expect_event(4, "coll_second");
        tick();
        check("coll_drained", {24'd0, pend}, 32'd0);

        // Randomized traffic, checked every cycle by the model.
        for (int c = 0; c < 3000; c++) begin
            flip = 8'($urandom & $urandom & $urandom);
            in_v = in_v ^ flip;
            en_v = 8'($urandom | $urandom);
            rdy  = ($urandom_range(0, 3) != 0);
            clr  = ($urandom_range(0, 15) == 0);
            if (c % 997 == 500) begin
                rst = 1'b1;
                #2;
                rst = 1'b0;
            end
            tick();
        end
        en_v = 8'hFF;
        rdy  = 1'b0;
        clr  = 1'b0;

        // Falling-edge instance: fall on ch0 while the counter reads 100, then reset mid-present.
        rst_f = 1'b0;
        repeat (100) tick();
        in_f = 8'hFE;
        tick();
        check("fall_pending", {24'd0, pend_f}, 32'h01);
        tick();
        check("fall_valid", {31'd0, valid_f}, 32'd1);
        check("fall_index", {29'd0, idx_f}, 32'd0);
`ifdef EDGE_EVENT_TIMESTAMP_EN
        check("fall_timestamp", {16'd0, ts_f}, 32'd100);
`endif
        rst_f = 1'b1;
        #1;
        check("fall_rst_valid", {31'd0, valid_f}, 32'd0);
        check("fall_rst_pending", {24'd0, pend_f}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
